// File: rtl/generic_demux_frame_if.sv
// Word-in / frame-out bundle for generic_demux_frame.
// master = upstream producer plus frame consumer; slave = the assembler.
interface generic_demux_frame_if #(
  parameter int unsigned N = 2,
  parameter int unsigned K = 8
);
  localparam int unsigned NS = 1 << N;

  logic            in_valid;
  logic            in_ready;
  logic [K-1:0]    in_data;
  logic [N-1:0]    in_sel;
  logic            mode;
  logic [NS*K-1:0] D;
  logic [NS-1:0]   slot_valid;
  logic            frame_valid;
  logic            frame_ack;

  modport master (
    output in_valid, in_data, in_sel, mode, frame_ack,
    input  in_ready, D, slot_valid, frame_valid
  );

  modport slave (
    input  in_valid, in_data, in_sel, mode, frame_ack,
    output in_ready, D, slot_valid, frame_valid
  );
endinterface

// File: rtl/generic_demux_frame.sv
// Sequential demultiplexer / frame assembler: steers K-bit words into 2^N slots
// and holds the completed frame until the consumer acknowledges it.
module generic_demux_frame #(
  parameter int unsigned N = 2,
  parameter int unsigned K = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  generic_demux_frame_if.slave  bus
);
  localparam int unsigned NS = 1 << N;
  localparam int unsigned DW = NS * K;

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   d_q, d_d;
  logic [NS-1:0]   slot_valid_q, slot_valid_d;
  logic [N-1:0]    ptr_q, ptr_d;
  logic            mode_q, mode_d;
  logic            in_ready_q, in_ready_d;
  logic            frame_valid_q, frame_valid_d;

  logic            accept_c;
  logic            mode_eff_c;
  logic [N-1:0]    slot_c;
  logic [NS-1:0]   slot_oh_c;

  // Slot decode; mode comes live from the port only on a frame's first word.
  always_comb begin
    accept_c   = bus.in_valid && in_ready_q;
    mode_eff_c = (state_q == IDLE) ? bus.mode : mode_q;
    slot_c     = mode_eff_c ? ptr_q : bus.in_sel;
    slot_oh_c  = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      slot_oh_c[i] = (slot_c == N'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    d_d          = d_q;
    slot_valid_d = slot_valid_q;
    ptr_d        = ptr_q;
    mode_d       = mode_q;
    case (state_q)
      IDLE, FILL: begin
        if (accept_c) begin
          mode_d = mode_eff_c;
          for (int unsigned i = 0; i < NS; i++) begin
            if (slot_oh_c[i]) d_d[i*K +: K] = bus.in_data;
          end
          slot_valid_d = slot_valid_q | slot_oh_c;
          if (mode_eff_c) ptr_d = ptr_q + N'(1);
          // Overwrites in addressed mode never complete the frame on their own.
          state_d = (&slot_valid_d) ? HOLD : FILL;
        end
      end
      HOLD: begin
        if (bus.frame_ack) begin
          state_d      = IDLE;
          slot_valid_d = '0;
          ptr_d        = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d    = (state_d != HOLD);
    frame_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      d_q           <= '0;
      slot_valid_q  <= '0;
      ptr_q         <= '0;
      mode_q        <= 1'b0;
      in_ready_q    <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      d_q           <= d_d;
      slot_valid_q  <= slot_valid_d;
      ptr_q         <= ptr_d;
      mode_q        <= mode_d;
      in_ready_q    <= in_ready_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.D           = d_q;
  assign bus.slot_valid  = slot_valid_q;
  assign bus.frame_valid = frame_valid_q;
endmodule
